// File: rtl/vram_synth.sv
// 32K x 16 single-port synchronous VRAM for the HuC6270 VDC.
// Includes an optional zero-fill sweep that runs after every reset release.
module vram_synth #(
  parameter int ADDR_W         = 15,
  parameter int DATA_W         = 16,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter     INIT_FILE      = ""
) (
  input  logic              clock,
  input  logic              reset_N,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q,
  output logic              init_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] clr_addr;
  logic              clr_done;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;

  // The sweep clears one word per cycle.
  // It sets the done flag on the same edge that writes the last word.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      clr_addr <= '0;
      clr_done <= !CLEAR_ON_RESET;
    end else if (!clr_done) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == '1) clr_done <= 1'b1;
    end
  end

  always_comb begin
    ram_we   = wren;
    ram_addr = address;
    ram_data = data;
    if (!clr_done) begin
      ram_we   = 1'b1;
      ram_addr = clr_addr;
      ram_data = '0;
    end
  end

  // While reset is held the sweep mux targets word 0 with zero data.
  // The sweep zeroes that word after release anyway, so the effect is never observable.
  always_ff @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_data;
  end

  // Read port: registered address, new-data on write, forced to zero while clearing.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      q <= '0;
    end else if (!clr_done) begin
      q <= '0;
    end else if (wren) begin
      q <= data;
    end else begin
      q <= mem[address];
    end
  end

  assign init_done = clr_done;

endmodule

// File: tb/tb_vram_synth.sv
// Directed bench for vram_synth: clear sweep, read/write latency, write-through, reset behaviour.
// A second instance built with CLEAR_ON_RESET=0 checks that contents survive a reset.
module tb_vram_synth;

  logic        clock = 1'b0;
  logic        reset_N;
  logic        reset2_N;
  logic        wren;
  logic [14:0] address;
  logic [15:0] data;
  logic [15:0] q;
  logic [15:0] q2;
  logic        init_done;
  logic        init_done2;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  vram_synth #(
    .ADDR_W        (15),
    .DATA_W        (16),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clock    (clock),
    .reset_N  (reset_N),
    .address  (address),
    .data     (data),
    .wren     (wren),
    .q        (q),
    .init_done(init_done)
  );

  vram_synth #(
    .ADDR_W        (15),
    .DATA_W        (16),
    .CLEAR_ON_RESET(1'b0)
  ) dut_keep (
    .clock    (clock),
    .reset_N  (reset2_N),
    .address  (address),
    .data     (data),
    .wren     (wren),
    .q        (q2),
    .init_done(init_done2)
  );

  typedef struct {
    logic        wr;
    logic [14:0] addr;
    logic [15:0] din;
    logic [15:0] exp_q;
    string       name;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int nz;
    int cyc;

    vecs[0]  = '{1'b0, 15'h0000, 16'h0000, 16'h0000, "idle_rd_0000"};
    vecs[1]  = '{1'b0, 15'h1234, 16'h0000, 16'h0000, "idle_rd_1234"};
    vecs[2]  = '{1'b0, 15'h7FFF, 16'h0000, 16'h0000, "idle_rd_7fff"};
    vecs[3]  = '{1'b1, 15'h0010, 16'hBEEF, 16'hBEEF, "wr_0010"};
    vecs[4]  = '{1'b0, 15'h0000, 16'h0000, 16'h0000, "rd_0000_between"};
    vecs[5]  = '{1'b0, 15'h0010, 16'h0000, 16'hBEEF, "rd_0010_latency"};
    vecs[6]  = '{1'b1, 15'h0100, 16'h5A5A, 16'h5A5A, "rdw_0100"};
    vecs[7]  = '{1'b0, 15'h0010, 16'h0000, 16'hBEEF, "rd_0010_again"};
    vecs[8]  = '{1'b0, 15'h0100, 16'h0000, 16'h5A5A, "rd_0100"};
    vecs[9]  = '{1'b1, 15'h0000, 16'h0001, 16'h0001, "wr_0000"};
    vecs[10] = '{1'b1, 15'h7FFF, 16'hFFFF, 16'hFFFF, "wr_7fff"};
    vecs[11] = '{1'b0, 15'h0000, 16'h0000, 16'h0001, "rd_0000"};
    vecs[12] = '{1'b0, 15'h0001, 16'h0000, 16'h0000, "rd_0001_neighbour"};
    vecs[13] = '{1'b0, 15'h7FFE, 16'h0000, 16'h0000, "rd_7ffe_neighbour"};
    vecs[14] = '{1'b0, 15'h0005, 16'h0000, 16'h0000, "rd_0005_sweep_write_dropped"};

    reset_N  = 1'b0;
    reset2_N = 1'b0;
    wren     = 1'b0;
    address  = '0;
    data     = '0;
    repeat (3) step();
    check("reset_q", q, 0);
    check("reset_init_done", init_done, 0);
    check("keep_reset_q", q2, 0);
    check("keep_reset_init_done", init_done2, 1);

    // Writes attempted during the sweep must be dropped.
    reset_N  = 1'b1;
    reset2_N = 1'b1;
    wren     = 1'b1;
    address  = 15'h0005;
    data     = 16'h1111;
    nz       = 0;
    for (int n = 1; n <= 32768; n++) begin
      step();
      if (n == 200) wren = 1'b0;
      if (q !== 16'h0000) nz++;
      if (n == 32767) check("init_done_before_last", init_done, 0);
    end
    check("init_done_at_32768", init_done, 1);
    check("sweep_q_nonzero_cycles", nz, 0);

    for (int i = 0; i < 15; i++) begin
      wren    = vecs[i].wr;
      address = vecs[i].addr;
      data    = vecs[i].din;
      step();
      check(vecs[i].name, q, vecs[i].exp_q);
    end
    wren = 1'b0;

    // Reset asserted between clock edges must clear q asynchronously.
    wren    = 1'b1;
    address = 15'h0020;
    data    = 16'hCAFE;
    step();
    wren = 1'b0;
    check("wr_0020", q, 16'hCAFE);
    check("keep_wr_0020", q2, 16'hCAFE);
    #3;
    reset_N  = 1'b0;
    reset2_N = 1'b0;
    #1;
    check("async_q_clear", q, 0);
    check("keep_async_q_clear", q2, 0);
    #2;
    reset_N  = 1'b1;
    reset2_N = 1'b1;
    check("resweep_init_done_low", init_done, 0);
    check("keep_init_done_after_reset", init_done2, 1);

    // Abort the sweep part-way; the restarted sweep must take the full length.
    repeat (100) step();
    check("mid_sweep_init_done", init_done, 0);
    reset_N = 1'b0;
    #2;
    reset_N = 1'b1;
    cyc = 0;
    while (!init_done && cyc < 40000) begin
      step();
      cyc++;
    end
    check("restart_sweep_len", cyc, 32768);

    address = 15'h0020;
    step();
    check("rd_0020_cleared", q, 0);
    check("keep_rd_0020_preserved", q2, 16'hCAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
